pkt_merger: RTL and testbench

PKT_MERGER -- requirements
Module: pkt_merger

---
 rtl/pkt_merger.sv | 120 ++++++++++++
 tb/tb_pkt_merger.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pkt_merger.sv
// Round-robin N:1 packet merger with a single output buffer. A buffered packet
// that downstream does not accept within drop_wait_in cycles is dropped.
`ifndef NUM_CHANS
`define NUM_CHANS 4
`endif
`ifndef PKT_BITS
`define PKT_BITS 32
`endif

module pkt_merger #(
    parameter int NUM_CHANNELS = `NUM_CHANS,
    parameter int PKT_BITS     = `PKT_BITS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [31:0]                      drop_wait_in,
    input  logic [NUM_CHANNELS*PKT_BITS-1:0] pkt_in_data_in,
    input  logic [NUM_CHANNELS-1:0]          pkt_in_vld_in,
    output logic [NUM_CHANNELS-1:0]          pkt_in_rdy_out,
    output logic [PKT_BITS-1:0]              pkt_out_data_out,
    output logic                             pkt_out_vld_out,
    input  logic                             pkt_out_rdy_in,
    output logic [1:0]                       mg_cnt_out
);
    localparam int IDX_W = $clog2(NUM_CHANNELS);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

    buf_state_e          state_q, state_d;
    logic [PKT_BITS-1:0] data_q, data_d;
    logic [31:0]         wait_q, wait_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [1:0]          mg_q, mg_d;

    logic                    full, out_xfer, drop, free, found, in_xfer;
    logic [32:0]             wait_inc;
    logic [IDX_W-1:0]        grant_idx;
    logic [NUM_CHANNELS-1:0] grant_oh;
    logic [PKT_BITS-1:0]     sel_data;

    assign full     = (state_q == FULL);
    assign out_xfer = full && pkt_out_rdy_in;
    // 33-bit compare so a saturated counter cannot wrap past the deadline.
    assign wait_inc = {1'b0, wait_q} + 33'd1;
    assign drop     = full && !pkt_out_rdy_in && (drop_wait_in != 32'd0)
                      && (wait_inc >= {1'b0, drop_wait_in});
    assign free     = !full || out_xfer || drop;

    // NOTE: every signal written in always_comb gets a default first, otherwise
    // paths that skip the assignment infer a latch.
    always_comb begin
        int cand;
        cand      = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_CHANNELS) cand = cand - NUM_CHANNELS;
            if (!found && pkt_in_vld_in[IDX_W'(cand)]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        sel_data = '0;
        grant_oh[grant_idx] = 1'b1;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (grant_idx == IDX_W'(c)) sel_data = pkt_in_data_in[c*PKT_BITS +: PKT_BITS];
        end
    end

    // Reset gates the grant so no source sees a handshake while the block is held.
    assign pkt_in_rdy_out = (reset && free && found) ? grant_oh : '0;
    assign in_xfer        = |pkt_in_rdy_out;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        wait_d  = wait_q;
        last_d  = last_q;
        mg_d    = {drop, out_xfer};
        if (in_xfer) begin
            state_d = FULL;
            data_d  = sel_data;
            wait_d  = '0;
            last_d  = grant_idx;
        end else if (out_xfer || drop) begin
            state_d = EMPTY;
        end else if (full && (wait_q != '1)) begin
            wait_d = wait_inc[31:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // The data buffer is reset as well because it drives an output directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            wait_q  <= '0;
            last_q  <= IDX_W'(NUM_CHANNELS - 1);
            mg_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            last_q  <= last_d;
            mg_q    <= mg_d;
        end
    end

    assign pkt_out_vld_out  = full;
    assign pkt_out_data_out = data_q;
    assign mg_cnt_out       = mg_q;

endmodule

// File: tb/tb_pkt_merger.sv
// Randomized bench for pkt_merger against a cycle-level reference model of
// the buffer, round-robin arbitration and drop deadline.
module tb_pkt_merger;
    localparam int NC = 4;
    localparam int PB = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     drop_wait_in;
    logic [NC*PB-1:0] pkt_in_data_in;
    logic [NC-1:0]   pkt_in_vld_in;
    logic [NC-1:0]   pkt_in_rdy_out;
    logic [PB-1:0]   pkt_out_data_out;
    logic            pkt_out_vld_out;
    logic            pkt_out_rdy_in;
    logic [1:0]      mg_cnt_out;

    int n_tests = 0;
    int n_fail  = 0;

    pkt_merger #(.NUM_CHANNELS(NC), .PKT_BITS(PB)) dut (
        .clk              (clk),
        .reset            (reset),
        .drop_wait_in     (drop_wait_in),
        .pkt_in_data_in   (pkt_in_data_in),
        .pkt_in_vld_in    (pkt_in_vld_in),
        .pkt_in_rdy_out   (pkt_in_rdy_out),
        .pkt_out_data_out (pkt_out_data_out),
        .pkt_out_vld_out  (pkt_out_vld_out),
        .pkt_out_rdy_in   (pkt_out_rdy_in),
        .mg_cnt_out       (mg_cnt_out)
    );

    always #5 clk = ~clk;

    // Sources keep a packet pending until it is granted.
    bit            src_vld [NC];
    logic [PB-1:0] src_data[NC];

    // Reference model of the merger.
    bit            m_full;
    logic [PB-1:0] m_data;
    longint        m_wait;
    int            m_last;
    logic [1:0]    m_mg;
    int            obs_drop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_wait = 0;
        m_last = NC - 1;
        m_mg   = 2'b00;
    endtask

    task automatic drive_sources();
        for (int c = 0; c < NC; c++) begin
            pkt_in_vld_in[c]            = src_vld[c];
            pkt_in_data_in[c*PB +: PB]  = src_data[c];
        end
    endtask

    // One clock: drive at negedge, check just after, update the model at posedge.
    // rdy_mode: 0 = low, 1 = high, 2 = random.
    task automatic cycle(input logic [NC-1:0] mask, input bit always_fill,
                         input int rdy_mode, input int dw);
        int            grant;
        bit            xfer, drp, free;
        logic [NC-1:0] exp_rdy;
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            if (!mask[c]) src_vld[c] = 1'b0;
            else if (!src_vld[c] && (always_fill || $urandom_range(1, 0) == 1)) begin
                src_vld[c]  = 1'b1;
                src_data[c] = PB'($urandom);
            end
        end
        drive_sources();
        pkt_out_rdy_in = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode == 1);
        drop_wait_in   = 32'(dw);
        #1;
        xfer  = m_full && pkt_out_rdy_in;
        drp   = m_full && !pkt_out_rdy_in && dw != 0 && (m_wait + 1 >= dw);
        free  = !m_full || xfer || drp;
        grant = -1;
        if (free)
            for (int k = 1; k <= NC; k++)
                if (grant < 0 && src_vld[(m_last + k) % NC]) grant = (m_last + k) % NC;
        exp_rdy = '0;
        if (grant >= 0) exp_rdy[grant] = 1'b1;
        check("rdy", 64'(pkt_in_rdy_out), 64'(exp_rdy));
        check("vld", 64'(pkt_out_vld_out), 64'(m_full));
        if (m_full) check("data", 64'(pkt_out_data_out), 64'(m_data));
        check("mg_cnt", 64'(mg_cnt_out), 64'(m_mg));
        if (mg_cnt_out[1]) obs_drop++;
        @(posedge clk);
        m_mg = {drp, xfer};
        if (grant >= 0) begin
            m_full = 1'b1;
            m_data = src_data[grant];
            m_wait = 0;
            m_last = grant;
            src_vld[grant] = 1'b0;
        end else if (xfer || drp) begin
            m_full = 1'b0;
        end else if (m_full) begin
            m_wait++;
        end
    endtask

    task automatic drain();
        repeat (2) cycle('0, 1'b1, 1, 0);
    endtask

    initial begin
        logic [NC-1:0] mask;
        int            dw;

        // Reset with every channel requesting: nothing may be granted.
        reset          = 1'b0;
        pkt_out_rdy_in = 1'b1;
        drop_wait_in   = 32'd0;
        for (int c = 0; c < NC; c++) begin
            src_vld[c]  = 1'b1;
            src_data[c] = PB'($urandom);
        end
        drive_sources();
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check("rst_vld",  64'(pkt_out_vld_out), 64'(0));
            check("rst_data", 64'(pkt_out_data_out), 64'(0));
            check("rst_mg",   64'(mg_cnt_out), 64'(0));
            check("rst_rdy",  64'(pkt_in_rdy_out), 64'(0));
        end
        @(posedge clk);
        #2 reset = 1'b1;

        // All channels valid, downstream always ready: strict rotation 0,1,2,3,...
        repeat (12) cycle(4'hF, 1'b1, 1, 0);

        // Only channel 2 valid: granted every cycle with no gaps.
        repeat (10) cycle(4'b0100, 1'b1, 1, 0);

        // Deadline of 4 with downstream stalled: periodic drop and reload.
        drain();
        repeat (14) cycle(4'b0001, 1'b1, 0, 4);

        // Dropping disabled: the held packet never moves and no drop pulses.
        drain();
        obs_drop = 0;
        repeat (100) cycle(4'hF, 1'b1, 0, 0);
        check("no_drop_dw0", 64'(obs_drop), 64'(0));

        // Downstream accepts in the fourth held cycle: transfer wins.
        drain();
        obs_drop = 0;
        cycle(4'b0001, 1'b1, 0, 4);
        repeat (3) cycle(4'b0001, 1'b1, 0, 4);
        cycle('0, 1'b1, 1, 4);
        cycle('0, 1'b1, 1, 4);
        check("deadline_xfer_no_drop", 64'(obs_drop), 64'(0));

        // Randomized traffic with a drop deadline that sometimes moves mid-hold.
        dw = 3;
        for (int seg = 0; seg < 100; seg++) begin
            mask = NC'($urandom_range(15, 0));
            for (int i = 0; i < 20; i++) begin
                if ($urandom_range(7, 0) == 0) dw = int'($urandom_range(6, 0));
                cycle(mask, 1'b0, 2, dw);
            end
        end

        // Reset mid-operation while full: buffer discarded at once.
        repeat (3) cycle(4'hF, 1'b1, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("midrst_vld",  64'(pkt_out_vld_out), 64'(0));
        check("midrst_data", 64'(pkt_out_data_out), 64'(0));
        check("midrst_mg",   64'(mg_cnt_out), 64'(0));
        check("midrst_rdy",  64'(pkt_in_rdy_out), 64'(0));
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (8) cycle(4'hF, 1'b1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
